// File: rtl/seq_detect_pkg.sv
// Shared helpers for the parameterised serial sequence detector: state width,
// elaboration-time KMP fallback computation and overlap-mode encoding.
package seq_detect_pkg;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_e;

  function automatic int state_w(input int pat_w);
    int w;
    w = $clog2(pat_w);
    return (w < 1) ? 1 : w;
  endfunction

  // Longest pattern prefix (shorter than the whole pattern) that ends the
  // received string "first k pattern bits followed by b". The pattern's
  // first bit lives at pat[pat_w-1].
  function automatic int kmp_next(input logic [15:0] pat, input int pat_w,
                                  input int k, input logic b);
    int          best;
    logic        ok;
    logic [16:0] seq;
    best = 0;
    seq  = '0;
    for (int i = 0; i < k; i++) seq[i] = pat[pat_w-1-i];
    seq[k] = b;
    for (int l = 1; (l <= k + 1) && (l < pat_w); l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        if (pat[pat_w-1-i] != seq[k+1-l+i]) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detect_satcnt.sv
// Saturating match counter with synchronous clear; holds at all-ones.
module seq_detect_satcnt #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr,
  input  logic             Inc,
  output logic [CNT_W-1:0] Cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a simultaneous increment.
  always_comb begin
    cnt_d = cnt_q;
    if (Clr) begin
      cnt_d = '0;
    end else if (Inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign Cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised Mealy serial pattern detector with overlap mode selection.
// Match counter is built only when SEQ_DETECT_CNT_EN is defined.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int               CNT_W   = 8,
  localparam int              SW      = state_w(PAT_W)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             In,
  input  logic             Ovl,
  input  logic             Clr,
  output logic             Match,
  output logic [CNT_W-1:0] MatchCnt,
  output logic [SW-1:0]    CS,
  output logic [SW-1:0]    NS
);

  localparam int            NST  = 2 ** SW;
  localparam logic [SW-1:0] LAST = SW'(PAT_W - 1);
  localparam logic [SW-1:0] LPS  = SW'(kmp_next(16'(PATTERN), PAT_W, PAT_W - 1, PATTERN[0]));

  logic [SW-1:0] fb_tbl [NST][2];
  logic [SW-1:0] cs_q, ns_d;
  logic          match_d;

  // Unreachable encodings (when PAT_W is not a power of two) fall back to 0.
  for (genvar k = 0; k < NST; k++) begin : g_fb_state
    for (genvar b = 0; b < 2; b++) begin : g_fb_bit
      if (k < PAT_W) begin : g_live
        assign fb_tbl[k][b] = SW'(kmp_next(16'(PATTERN), PAT_W, k, 1'(b)));
      end else begin : g_pad
        assign fb_tbl[k][b] = '0;
      end
    end
  end

  always_comb begin
    ns_d    = cs_q;
    match_d = 1'b0;
    if (Rst) begin
      ns_d = '0;
    end else if (En) begin
      if ((cs_q == LAST) && (In == PATTERN[0])) begin
        match_d = 1'b1;
        ns_d    = (ovl_mode_e'(Ovl) == OVL_ON) ? LPS : '0;
      end else begin
        ns_d = fb_tbl[cs_q][In];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) cs_q <= '0;
    else     cs_q <= ns_d;
  end

  assign CS    = cs_q;
  assign NS    = ns_d;
  assign Match = match_d;

`ifdef SEQ_DETECT_CNT_EN
  seq_detect_satcnt #(
    .CNT_W (CNT_W)
  ) u_satcnt (
    .Clk (Clk),
    .Rst (Rst),
    .Clr (Clr),
    .Inc (match_d),
    .Cnt (MatchCnt)
  );
`else
  logic unused_clr;
  assign unused_clr = Clr;
  assign MatchCnt   = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default 1010 detector, a 1110 variant
// and a 2-bit-counter variant share one stimulus stream.
module tb_seq_detect_param;

`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       Clk, Rst, En, In, Ovl, Clr;
  logic       m_a, m_b, m_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [1:0] cs_a, ns_a, cs_b, ns_b, cs_c, ns_c;

  int checks = 0;
  int errors = 0;

  int cs_ovl [8] = '{1, 2, 3, 2, 3, 2, 3, 2};
  int cs_nov [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  bit m_ovl  [8] = '{0, 0, 0, 1, 0, 1, 0, 1};
  bit m_nov  [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  bit strm   [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
  bit strm_b [5] = '{1, 1, 1, 1, 0};
  int cs_b_e [5] = '{1, 2, 3, 3, 0};
  bit m_b_e  [5] = '{0, 0, 0, 0, 1};

  seq_detect_param dut_a (
    .Clk(Clk), .Rst(Rst), .En(En), .In(In), .Ovl(Ovl), .Clr(Clr),
    .Match(m_a), .MatchCnt(cnt_a), .CS(cs_a), .NS(ns_a)
  );

  seq_detect_param #(.PATTERN(4'b1110)) dut_b (
    .Clk(Clk), .Rst(Rst), .En(En), .In(In), .Ovl(Ovl), .Clr(Clr),
    .Match(m_b), .MatchCnt(cnt_b), .CS(cs_b), .NS(ns_b)
  );

  seq_detect_param #(.CNT_W(2)) dut_c (
    .Clk(Clk), .Rst(Rst), .En(En), .In(In), .Ovl(Ovl), .Clr(Clr),
    .Match(m_c), .MatchCnt(cnt_c), .CS(cs_c), .NS(ns_c)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Scoreboard helpers
  function automatic int exp_cnt(input int n, input int maxv);
    if (!CNT_ON) return 0;
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic en_v, input logic in_v);
    En = en_v;
    In = in_v;
    #2;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    En  = 1'b0;
    Clr = 1'b0;
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    int n;
    Rst = 1'b1; En = 1'b0; In = 1'b0; Ovl = 1'b0; Clr = 1'b0;
    #2;
    chk("rst_match_a", m_a, 0);
    chk("rst_ns_a", ns_a, 0);
    chk("rst_ns_b", ns_b, 0);
    chk("rst_ns_c", ns_c, 0);
    tick();
    tick();
    chk("rst_cs_a", cs_a, 0);
    chk("rst_cs_b", cs_b, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_c", cnt_c, 0);

    // Overlapping detection of 1010 in 10101010
    Ovl = 1'b1;
    do_reset();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, strm[i]);
      chk("ovl_match", m_a, m_ovl[i]);
      chk("ovl_ns", ns_a, cs_ovl[i]);
      chk("ovl_cnt_pre", cnt_a, exp_cnt(n, 255));
      if (m_ovl[i]) n++;
      tick();
      chk("ovl_cs", cs_a, cs_ovl[i]);
      chk("ovl_cnt_post", cnt_a, exp_cnt(n, 255));
    end
    chk("ovl_cnt_total", cnt_a, exp_cnt(3, 255));

    // Clear alone zeroes the counter and leaves state alone
    Clr = 1'b1;
    drive(1'b0, 1'b0);
    tick();
    Clr = 1'b0;
    chk("clr_cnt", cnt_a, 0);
    chk("clr_cs", cs_a, 2);

    // Non-overlapping detection of the same stream
    Ovl = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, strm[i]);
      chk("nov_match", m_a, m_nov[i]);
      tick();
      chk("nov_cs", cs_a, cs_nov[i]);
    end
    chk("nov_cnt_total", cnt_a, exp_cnt(2, 255));

    // Pattern 1110 on 11110: state holds at 3 on the extra 1
    Ovl = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, strm_b[i]);
      chk("p1110_match", m_b, m_b_e[i]);
      chk("p1110_ns", ns_b, cs_b_e[i]);
      tick();
      chk("p1110_cs", cs_b, cs_b_e[i]);
    end

    // En gap mid-sequence
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, strm[i]);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      chk("gap_match", m_a, 0);
      chk("gap_ns", ns_a, 3);
      tick();
      chk("gap_cs", cs_a, 3);
    end
    drive(1'b1, 1'b0);
    chk("gap_final_match", m_a, 1);
    tick();
    chk("gap_final_cs", cs_a, 2);

    // Reset mid-sequence overrides a would-be match
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, strm[i]);
      tick();
    end
    chk("midrst_cs_pre", cs_a, 3);
    Rst = 1'b1;
    drive(1'b1, 1'b0);
    chk("midrst_match", m_a, 0);
    chk("midrst_ns", ns_a, 0);
    tick();
    Rst = 1'b0;
    chk("midrst_cs", cs_a, 0);
    drive(1'b1, 1'b0);
    chk("midrst_after_match", m_a, 0);
    tick();
    chk("midrst_after_cs", cs_a, 0);

    // Ovl toggling mid-sequence does not disturb progress
    do_reset();
    for (int i = 0; i < 3; i++) begin
      Ovl = i[0];
      drive(1'b1, strm[i]);
      tick();
      chk("ovl_toggle_cs", cs_a, cs_ovl[i]);
    end
    Ovl = 1'b1;
    drive(1'b1, 1'b0);
    chk("ovl_toggle_match", m_a, 1);
    tick();
    chk("ovl_toggle_end_cs", cs_a, 2);

    // 2-bit counter saturation over five overlapping matches
    Ovl = 1'b1;
    do_reset();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, strm[i % 8]);
      chk("sat_match", m_c, (i >= 3) && (i % 2 == 1));
      if ((i >= 3) && (i % 2 == 1)) n++;
      tick();
      chk("sat_cnt", cnt_c, exp_cnt(n, 3));
    end
    chk("sat_cnt_total", cnt_c, exp_cnt(5, 3));

    // Clear with a simultaneous match
    drive(1'b1, 1'b1);
    tick();
    Clr = 1'b1;
    drive(1'b1, 1'b0);
    chk("clr_match", m_c, 1);
    tick();
    Clr = 1'b0;
    chk("clr_match_cnt", cnt_c, 0);
    chk("clr_match_cs", cs_c, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 4'b1010, target sequence; PATTERN[PAT_W-1] is the first bit received.
REQ-003 SHALL have parameter CNT_W, default 8, match-counter width, legal range 1..32.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port En  input  1  sample qualifier; In is consumed only when En=1.
REQ-007 SHALL have port In  input  1  serial data bit.
REQ-008 SHALL have port Ovl  input  1  mode; 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port Clr  input  1  synchronous clear of MatchCnt only.
REQ-010 SHALL have port Match  output  1  Mealy match flag, combinational from CS, In, En.
REQ-011 SHALL have port MatchCnt  output  CNT_W  saturating count of matches.
REQ-012 SHALL have port CS  output  SW  current state; SW = max(1, clog2(PAT_W)).
REQ-013 SHALL have port NS  output  SW  next state, combinational.

Function
REQ-014 State k (0..PAT_W-1) SHALL mean the last k consumed bits equal the first k pattern bits.
REQ-015 From state k with En=1 and In equal to pattern bit k, NS SHALL be k+1 when k<PAT_W-1.
REQ-016 From state k with En=1 and In mismatching, NS SHALL be the longest proper prefix of the pattern that is a suffix of the received prefix plus In (KMP fallback), computed at elaboration.
REQ-017 Match SHALL be 1 iff Rst=0, En=1, CS=PAT_W-1 and In equals pattern bit PAT_W-1.
REQ-018 On a match with Ovl=1, NS SHALL be the longest proper prefix-suffix length of the full pattern; with Ovl=0, NS SHALL be 0.
REQ-019 With En=0, NS SHALL equal CS and Match SHALL be 0.
REQ-020 Ovl SHALL be sampled only in the cycle a match occurs; changing it mid-sequence SHALL not alter CS.
REQ-021 MatchCnt SHALL increment by 1 on the rising edge following a cycle with Match=1, saturating at 2^CNT_W-1 without wrap.
REQ-022 Clr=1 SHALL set MatchCnt to 0 at the next edge, taking priority over a simultaneous match; CS is unaffected.
REQ-023 Latency: Match SHALL be asserted in the same cycle the final pattern bit is presented; MatchCnt SHALL reflect it one cycle later.

Reset
REQ-024 Rst=1 at a rising edge SHALL set CS=0 and MatchCnt=0, overriding En, Clr and any match.
REQ-025 While Rst=1, Match SHALL be 0 and NS SHALL be 0.
REQ-026 Reset mid-sequence SHALL discard partial progress; detection restarts from state 0.

Configuration
REQ-027 Macro SEQ_DETECT_CNT_EN defined SHALL compile in the match counter per REQ-021/022.
REQ-028 Without SEQ_DETECT_CNT_EN, MatchCnt SHALL be tied to 0, Clr ignored, and no counter flops synthesised.

Structure
REQ-029 Package seq_detect_pkg SHALL hold the state-width function, the elaboration-time prefix-function (fallback table) function and the mode encoding constants OVL_ON/OVL_OFF.
REQ-030 Saturating counter SHALL be sub-module seq_detect_satcnt (parameter CNT_W; ports Clk, Rst, Clr, Inc, Cnt).
REQ-031 Next-state logic SHALL be a combinational process indexed by the elaborated fallback table; no per-pattern hand-coded states.

Verification
REQ-032 Defaults, Ovl=1, En=1, stream 1,0,1,0,1,0,1,0 -> Match=1 on bits 4, 6, 8; MatchCnt=3.
REQ-033 Defaults, Ovl=0, same stream -> Match=1 on bits 4 and 8 only; MatchCnt=2.
REQ-034 PATTERN=4'b1110, Ovl=1, stream 1,1,1,1,0 -> CS holds 3 on 4th bit, Match=1 on bit 5 only.
REQ-035 Defaults, stream 1,0,1 then En=0 for 3 cycles with In=0, then En=1 In=0 -> CS stays 3 during gap, Match=1 only on final bit.
REQ-036 CNT_W=2, SEQ_DETECT_CNT_EN defined, 5 overlapping matches -> MatchCnt=3; Clr with simultaneous match -> MatchCnt=0.
REQ-037 Stream 1,0,1 then Rst=1 one cycle, then 0 -> CS=0 after reset, no Match.
